d_cache: RTL and testbench

- Two-way set-associative, write-back, write-allocate data cache between the CPU load/store port and a block-wide memory interface.
- Serves byte, halfword and word loads and stores with RISC-V funct3-style size and sign encoding on `strobe`.
- On a miss it evicts the LRU line, writing it back first if dirty, then refills and completes as a hit.

---
 rtl/d_cache.sv | 193 +++++++++++++++++++
 tb/tb_d_cache.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache.sv
// Two-way set-associative write-back, write-allocate data cache.
// Misses evict the LRU line (written back if dirty), refill, then hit.
module d_cache #(
    parameter int BLOCK_SIZE    = 8,
    parameter int TOTAL_LINES   = 256,
    parameter int ASSOCIATIVITY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             address,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writeData,
    input  logic [2:0]              strobe,
    output logic [31:0]             readData,
    output logic                    valid,
    input  logic                    memBusy,
    output logic [31:0]             memAddress,
    output logic                    memRead,
    input  logic [BLOCK_SIZE*8-1:0] memReadData,
    output logic                    memWrite,
    output logic [BLOCK_SIZE*8-1:0] memWriteData
);

    localparam int OFF  = $clog2(BLOCK_SIZE);
    localparam int SETS = TOTAL_LINES / ASSOCIATIVITY;
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 32 - OFF - IDX;
    localparam int LW   = BLOCK_SIZE * 8;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

    state_t r_state, w_next;

    logic [LW-1:0]   r_data [2][SETS];
    logic [TAGW-1:0] r_tag  [2][SETS];
    logic [SETS-1:0] r_valid [2];
    logic [SETS-1:0] r_dirty [2];
    logic [SETS-1:0] r_lru;

    logic [TAGW-1:0] r_tag_q;
    logic [IDX-1:0]  r_idx_q;
    logic            r_way;

    logic [TAGW-1:0] w_tag;
    logic [IDX-1:0]  w_idx;
    logic [OFF-1:0]  w_off;
    logic [OFF-1:0]  w_boff;
    logic            w_req;
    logic            w_hit0;
    logic            w_hit1;
    logic            w_hit;
    logic            w_hway;
    logic            w_vict;
    logic            w_vdirty;
    logic [LW-1:0]   w_line;
    logic [LW-1:0]   w_sh;
    logic [31:0]     w_raw;
    logic [31:0]     w_ext;
    logic [31:0]     w_bmask;
    logic [LW-1:0]   w_mask;
    logic [LW-1:0]   w_wsh;
    logic [LW-1:0]   w_new;
    logic            w_hit_go;
    logic            w_fill_go;

    assign w_tag = address[31:OFF+IDX];
    assign w_idx = address[OFF+IDX-1:OFF];
    assign w_off = address[OFF-1:0];
    assign w_req = read | write;

    assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit  = w_hit0 | w_hit1;
    assign w_hway = w_hit1;

    assign w_vict = !r_valid[0][w_idx] ? 1'b0 :
                    !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_vdirty = r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx];

    // Access is aligned down to its size so it never crosses a line.
    always_comb begin
        w_boff  = w_off & ~OFF'(3);
        w_bmask = 32'hFFFF_FFFF;
        unique case (strobe[1:0])
            2'b00: begin
                w_boff  = w_off;
                w_bmask = 32'h0000_00FF;
            end
            2'b01: begin
                w_boff  = w_off & ~OFF'(1);
                w_bmask = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign w_line = r_data[w_hway][w_idx];
    assign w_sh   = w_line >> {w_boff, 3'b000};
    assign w_raw  = w_sh[31:0];

    always_comb begin
        w_ext = w_raw;
        unique case (strobe[1:0])
            2'b00: w_ext = strobe[2] ? {24'h0, w_raw[7:0]} :
                                       {{24{w_raw[7]}}, w_raw[7:0]};
            2'b01: w_ext = strobe[2] ? {16'h0, w_raw[15:0]} :
                                       {{16{w_raw[15]}}, w_raw[15:0]};
            default: ;
        endcase
    end

    assign w_mask = LW'(w_bmask) << {w_boff, 3'b000};
    assign w_wsh  = LW'(writeData) << {w_boff, 3'b000};
    assign w_new  = (w_line & ~w_mask) | (w_wsh & w_mask);

    assign memWriteData = r_data[r_way][r_idx_q];

    always_comb begin
        w_next     = r_state;
        valid      = 1'b0;
        readData   = 32'h0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memAddress = 32'h0;
        w_hit_go   = 1'b0;
        w_fill_go  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && w_hit) begin
                    valid    = 1'b1;
                    readData = w_ext;
                    w_hit_go = 1'b1;
                end else if (w_req) begin
                    w_next = w_vdirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                memWrite   = 1'b1;
                memAddress = {r_tag[r_way][r_idx_q], r_idx_q, {OFF{1'b0}}};
                if (!memBusy) w_next = S_FILL;
            end
            S_FILL: begin
                memRead    = 1'b1;
                memAddress = {r_tag_q, r_idx_q, {OFF{1'b0}}};
                if (!memBusy) begin
                    w_next    = S_IDLE;
                    w_fill_go = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru      <= '0;
            r_tag_q    <= '0;
            r_idx_q    <= '0;
            r_way      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_req && !w_hit) begin
                r_tag_q <= w_tag;
                r_idx_q <= w_idx;
                r_way   <= w_vict;
            end
            if (w_hit_go) begin
                r_lru[w_idx] <= ~w_hway;
                if (write) r_dirty[w_hway][w_idx] <= 1'b1;
            end
            if (w_fill_go) begin
                r_valid[r_way][r_idx_q] <= 1'b1;
                r_dirty[r_way][r_idx_q] <= 1'b0;
            end
        end
    end

    // Line payload and tags carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_hit_go && write) r_data[w_hway][w_idx] <= w_new;
        if (w_fill_go) begin
            r_data[r_way][r_idx_q] <= memReadData;
            r_tag[r_way][r_idx_q]  <= r_tag_q;
        end
    end

endmodule

// File: tb/tb_d_cache.sv
// Random and directed bench for d_cache against a flat-memory
// reference with a recency-ordered residency model per set.
module tb_d_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writeData = '0;
    logic [2:0]  strobe = '0;
    logic [31:0] readData;
    logic        valid;
    logic        memBusy = 1'b0;
    logic [31:0] memAddress;
    logic        memRead;
    logic [63:0] memReadData = '0;
    logic        memWrite;
    logic [63:0] memWriteData;

    always #5 clk = ~clk;

    d_cache #(
        .BLOCK_SIZE(8),
        .TOTAL_LINES(256),
        .ASSOCIATIVITY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .address(address),
        .read(read),
        .write(write),
        .writeData(writeData),
        .strobe(strobe),
        .readData(readData),
        .valid(valid),
        .memBusy(memBusy),
        .memAddress(memAddress),
        .memRead(memRead),
        .memReadData(memReadData),
        .memWrite(memWrite),
        .memWriteData(memWriteData)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] mem  [bit [31:0]];
    logic [7:0] gold [bit [31:0]];
    bit [31:0]  res  [128][$];
    bit         dirty [bit [31:0]];
    bit [31:0]  wb_q[$];
    bit [63:0]  wbd_q[$];
    bit [31:0]  fill_q[$];

    function automatic logic [7:0] dflt(bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(bit [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] gold_rd(bit [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    function automatic logic [63:0] mem_line(bit [31:0] a);
        logic [63:0] l;
        for (int k = 0; k < 8; k++) l[8*k +: 8] = mem_rd((a & ~32'h7) + k);
        return l;
    endfunction

    function automatic logic [63:0] gold_line(bit [31:0] a);
        logic [63:0] l;
        for (int k = 0; k < 8; k++) l[8*k +: 8] = gold_rd((a & ~32'h7) + k);
        return l;
    endfunction

    function automatic int size_of(logic [2:0] st);
        return (st[1:0] == 2'b00) ? 1 : (st[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(bit [31:0] a, logic [2:0] st);
        int sz;
        bit [31:0] base;
        logic [31:0] v;
        sz = size_of(st);
        base = a & ~(sz - 1);
        v = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = gold_rd(base + k);
        if (!st[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!st[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic put_line(input bit [31:0] a, input logic [63:0] l);
        for (int k = 0; k < 8; k++) begin
            mem[a + k]  = l[8*k +: 8];
            gold[a + k] = l[8*k +: 8];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) res[i].delete();
        dirty.delete();
        gold = mem;
    endtask

    // Memory side: random busy, combinational-looking line source.
    initial begin
        forever begin
            @(negedge clk);
            memBusy = ($urandom % 2) == 1;
            memReadData = mem_line(memAddress);
            if (rst && memWrite && !memBusy) begin
                wb_q.push_back(memAddress);
                wbd_q.push_back(memWriteData);
                check("wb_data", memWriteData, gold_line(memAddress));
                for (int k = 0; k < 8; k++)
                    mem[memAddress + k] = memWriteData[8*k +: 8];
            end
            if (rst && memRead && !memBusy) fill_q.push_back(memAddress);
        end
    end

    task automatic access(input bit wr, input bit rd, input bit [31:0] a,
                          input logic [2:0] st, input logic [31:0] wd,
                          output logic [31:0] got);
        int cyc;
        int s;
        int sz;
        bit [31:0] blk;
        bit [31:0] vic;
        bit hit;
        bit exp_wb;
        logic [31:0] exp;
        blk = a & ~32'h7;
        s = int'((a >> 3) & 32'h7F);
        hit = 0;
        vic = '0;
        for (int i = 0; i < res[s].size(); i++)
            if (res[s][i] == blk) hit = 1;
        exp_wb = 0;
        if (!hit && res[s].size() == 2) begin
            vic = res[s][0];
            exp_wb = dirty.exists(vic) && dirty[vic];
        end
        exp = load_val(a, st);
        wb_q.delete();
        wbd_q.delete();
        fill_q.delete();
        @(negedge clk);
        address = a;
        read = rd;
        write = wr;
        writeData = wd;
        strobe = st;
        #1;
        cyc = 0;
        while (!valid && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        got = readData;
        check("valid_seen", valid, 1);
        check("hit_latency", cyc == 0, hit);
        if (!wr) check("rdata", got, exp);
        @(posedge clk);
        #1;
        read = 0;
        write = 0;
        check("fill_count", fill_q.size(), hit ? 0 : 1);
        if (!hit && fill_q.size() > 0) check("fill_addr", fill_q[0], blk);
        check("wb_count", wb_q.size(), exp_wb);
        if (exp_wb && wb_q.size() > 0) check("wb_addr", wb_q[0], vic);
        if (!hit) begin
            if (res[s].size() == 2) begin
                dirty.delete(res[s][0]);
                void'(res[s].pop_front());
            end
            res[s].push_back(blk);
        end else begin
            for (int i = 0; i < res[s].size(); i++)
                if (res[s][i] == blk) begin
                    res[s].delete(i);
                    break;
                end
            res[s].push_back(blk);
        end
        if (wr) begin
            sz = size_of(st);
            for (int k = 0; k < sz; k++)
                gold[(a & ~(sz - 1)) + k] = wd[8*k +: 8];
            dirty[blk] = 1;
        end
    endtask

    logic [31:0] v;
    logic [2:0] st_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        put_line(32'h0000_0000, 64'hABCD1234_56789090);
        put_line(32'h0000_1000, 64'hAAAAAAAA_AABBCCAA);
        put_line(32'h00C0_1000, 64'hCCBBDDAA_CCBBDDAA);
        put_line(32'hAB00_0000, 64'hBBAABBAA_19092704);

        read = 1;
        address = 32'h4;
        strobe = 3'b010;
        #1;
        check("rst_valid", valid, 0);
        check("rst_rdata", readData, 0);
        check("rst_memRead", memRead, 0);
        check("rst_memWrite", memWrite, 0);
        check("rst_memAddr", memAddress, 0);
        repeat (2) @(negedge clk);
        read = 0;
        rst = 1;

        access(0, 1, 32'h0000_0004, 3'b010, 0, v);
        check("plan_cold_word", v, 32'hABCD1234);
        access(0, 1, 32'h0000_1005, 3'b100, 0, v);
        check("plan_ubyte", v, 32'h000000AA);
        access(1, 0, 32'h0000_1005, 3'b010, 32'hFAFAFFFF, v);
        access(0, 1, 32'h0000_0001, 3'b000, 0, v);
        check("plan_sbyte", v, 32'hFFFFFF90);
        access(0, 1, 32'h0000_0006, 3'b001, 0, v);
        check("plan_shalf", v, 32'hFFFFABCD);
        access(0, 1, 32'h00C0_1005, 3'b101, 0, v);
        check("plan_uhalf", v, 32'h0000DDAA);
        check("plan_wb1_n", wbd_q.size(), 1);
        if (wbd_q.size() > 0) begin
            check("plan_wb1_addr", wb_q[0], 32'h0000_1000);
            check("plan_wb1_data", wbd_q[0], 64'hFAFAFFFF_AABBCCAA);
        end
        access(1, 0, 32'h0000_0003, 3'b001, 32'h1111, v);
        access(1, 0, 32'h0000_0005, 3'b000, 32'hCC, v);
        access(0, 1, 32'h0000_0005, 3'b000, 0, v);
        check("plan_sbyte_cc", v, 32'hFFFFFFCC);
        for (int i = 0; i < 4; i++) access(0, 1, 32'h00C0_1005, 3'b101, 0, v);
        access(0, 1, 32'hAB00_0004, 3'b010, 0, v);
        check("plan_word2", v, 32'hBBAABBAA);
        check("plan_wb2_n", wbd_q.size(), 1);
        if (wbd_q.size() > 0) begin
            check("plan_wb2_addr", wb_q[0], 32'h0000_0000);
            check("plan_wb2_data", wbd_q[0], 64'hABCDCC34_11119090);
        end

        for (int n = 0; n < 400; n++) begin
            bit [31:0] a;
            int op;
            a = 32'h8000 + ($urandom % 4) * 32'h400 + ($urandom % 4) * 8
                + ($urandom % 8);
            op = $urandom % 4;
            access(op >= 2, op != 2, a, st_tab[$urandom % 5], $urandom, v);
        end

        begin
            int cyc;
            @(negedge clk);
            address = 32'h7000_0018;
            read = 1;
            strobe = 3'b010;
            #1;
            cyc = 0;
            while (!memRead && cyc < 200) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            check("mf_fill_seen", memRead, 1);
            rst = 0;
            #1;
            check("mf_memRead", memRead, 0);
            check("mf_memWrite", memWrite, 0);
            check("mf_memAddr", memAddress, 0);
            check("mf_valid", valid, 0);
            repeat (2) @(negedge clk);
            read = 0;
            rst = 1;
            model_reset();
            access(0, 1, 32'h7000_0018, 3'b010, 0, v);
            access(0, 1, 32'h0000_1005, 3'b100, 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
